iir_inverse_order2_serial: RTL
==============================

// Module: iir_inverse_order2_serial
// PURPOSE
//  Second-order inverse (equalising) IIR stage: recovers the original x stream from a
//  biquad-filtered stream by applying precomputed inverse coefficients (A/B form).
//  Sits downstream of the order-2 filter, at the receive end of the sample chain.
//  One shared multiplier, time-multiplexed over 5 MAC steps; valid/ready on both sides.
// PARAMETERS
//  bitwidth     32      sample width, signed two's complement, in and out
//  frac_bits    20      fractional bits of the Q-format coefficients
//  coeffs_file  "inv.txt"  5 binary integer coeffs, $readmemb, index 0..4 = c0,c1,c2 (ff), c3,c4 (fb)
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-high
//  in_valid   in   1         input sample valid
//  in_ready   out  1         block can accept a sample
//  x          in   bitwidth  encoded filtered sample (signed)
//  out_valid  out  1         y holds a result
//  out_ready  in   1         downstream accepts y
//  y          out  bitwidth  reconstructed sample (signed)
// BEHAVIOUR
//  - Reset: state=IDLE, z1=z2=0, acc=0, w=0, y=0, out_valid=0, in_ready=1.
//    rst has priority at every state; an in-flight sample is discarded, delay line cleared.
//  - States: IDLE -> RUN(k=0..4) -> OUT -> IDLE. in_ready = (state==IDLE); in_valid ignored elsewhere.
//  - IDLE: on in_valid & in_ready: acc <= x <<< frac_bits, k <= 0, go RUN.
//  - RUN, one product per cycle (single bitwidth x bitwidth multiplier):
//      k0: acc <= acc - c3*z1
//      k1: w   <= fit((acc - c4*z2) >>> frac_bits)
//      k2: acc <= c0*w
//      k3: acc <= acc + c1*z1
//      k4: y <= fit((acc + c2*z2) >>> frac_bits); z2 <= z1; z1 <= w; out_valid <= 1; go OUT
//  - Latency: out_valid high 5 clocks after the accept edge; min 7 clocks per sample.
//  - OUT: y and out_valid held stable until out_valid & out_ready; then out_valid <= 0, go IDLE.
//    Back-pressure indefinite; no sample lost or duplicated.
//  - Delay line z1/z2 updates only at k4; held through OUT and IDLE gaps.
//  - Arithmetic: products 2*bitwidth signed; acc 2*bitwidth+3 signed; >>> is arithmetic.
//    z1, z2, w stored at bitwidth. fit() defined under CONFIGURATION.
//  - Coefficients loaded once at init; constant at runtime; unaffected by rst.
// CONFIGURATION
//  IIR_INV_SAT_EN defined: fit() saturates to [-2^(bitwidth-1), 2^(bitwidth-1)-1].
//  IIR_INV_SAT_EN undefined: fit() keeps low bitwidth bits (two's-complement wrap).
//  Both w and y use the same fit(); no other behaviour changes.
// TESTING
//  1 Identity: c0=1048576, others 0; x=1000, then x=-7 -> y=1000, y=-7; out_valid 5 clk after accept.
//  2 Inverse of y=x+0.5x[n-1]: c0=1048576, c3=524288; x=1000,0,0,0 -> y=1000,-500,250,-125.
//  3 Back-pressure: out_ready=0 for 10 clk after out_valid -> y, out_valid stable, in_ready=0;
//    in_valid pulses ignored; release -> exactly one transfer, then in_ready=1.
//  4 Reset mid-RUN (k=2) -> next clk out_valid=0, in_ready=1, y=0; next sample from test 2
//    restarts at 1000 (delay line cleared).
//  5 Overflow: c0=2097152, x=32'h7FFFFFFF -> with IIR_INV_SAT_EN y=32'h7FFFFFFF;
//    without y=32'hFFFFFFFE.
//  6 Streaming: in_valid and out_ready held 1, 8 samples -> 8 outputs in order, 7-clk spacing.

Source files
------------

// File: rtl/iir_inverse_order2_serial.sv
// ---------------------------------------------------------------------------
// iir_inverse_order2_serial
//
// Second-order inverse (equalising) IIR stage. It rebuilds the original sample
// stream from a biquad-filtered stream using precomputed inverse coefficients
// in direct form II:
//   w[n] = x[n] - c3*w[n-1] - c4*w[n-2]
//   y[n] = c0*w[n] + c1*w[n-1] + c2*w[n-2]
// One signed bitwidth x bitwidth multiplier is shared over five MAC steps
// (k = 0..4). A sample is accepted in IDLE, y appears 5 clocks after the
// accept edge and is held in OUT until the downstream takes it. The minimum
// cost is therefore 7 clocks per sample.
//
// Coefficients arrive as one packed parameter vector, so they are fixed at
// elaboration and no reset touches them. Slot i holds coefficient ci:
//   coeffs[i*bitwidth +: bitwidth], i = 0..4 -> c0, c1, c2 (ff), c3, c4 (fb).
// Coefficients use the Q format set by frac_bits (1.0 = 2**frac_bits).
//
// Build option:
//   IIR_INV_SAT_EN  defined   -> w and y saturate to the signed bitwidth range.
//                   undefined -> w and y keep their low bitwidth bits (wrap).
//
// Ports:
//   clk        clock; all logic uses the rising edge
//   rst        synchronous reset, active-high. It drops any in-flight sample
//              and clears the delay line.
//   in_valid   input sample valid
//   in_ready   block can accept a sample (high only in IDLE)
//   x          filtered input sample, signed
//   out_valid  y holds a result
//   out_ready  downstream accepts y
//   y          reconstructed sample, signed
// ---------------------------------------------------------------------------
module iir_inverse_order2_serial #(
  parameter int                    bitwidth  = 32,
  parameter int                    frac_bits = 20,
  parameter logic [5*bitwidth-1:0] coeffs    = (5*bitwidth)'(64'd1 << frac_bits)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [bitwidth-1:0] x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [bitwidth-1:0] y
);

  // The accumulator has 3 guard bits above the full product width.
  localparam int AW = 2*bitwidth + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 k_q, k_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic signed [bitwidth-1:0] z1_q, z1_d, z2_q, z2_d;
  logic signed [bitwidth-1:0] w_q, w_d, y_q, y_d;
  logic                       out_valid_q, out_valid_d;

  logic signed [bitwidth-1:0]   coef, opnd;
  logic signed [2*bitwidth-1:0] prod;
  logic signed [AW-1:0]         prod_ext, sum, x_ext;
  logic signed [bitwidth-1:0]   fit_val;

  // Operand select for the shared multiplier. Each step pairs one coefficient
  // with the state word it weights. At k2, w_q already holds the value that
  // step k1 wrote.
  always_comb begin
    coef = '0;
    opnd = '0;
    case (k_q)
      3'd0: begin coef = coeffs[3*bitwidth +: bitwidth]; opnd = z1_q; end
      3'd1: begin coef = coeffs[4*bitwidth +: bitwidth]; opnd = z2_q; end
      3'd2: begin coef = coeffs[0*bitwidth +: bitwidth]; opnd = w_q;  end
      3'd3: begin coef = coeffs[1*bitwidth +: bitwidth]; opnd = z1_q; end
      3'd4: begin coef = coeffs[2*bitwidth +: bitwidth]; opnd = z2_q; end
      default: begin coef = '0; opnd = '0; end
    endcase
  end

  assign prod     = coef * opnd;
  assign prod_ext = AW'(prod);
  assign x_ext    = AW'(x) <<< frac_bits;

  // The feedback steps subtract, k2 starts a fresh sum, and the feed-forward
  // steps add.
  always_comb begin
    sum = acc_q + prod_ext;
    case (k_q)
      3'd0, 3'd1: sum = acc_q - prod_ext;
      3'd2:       sum = prod_ext;
      default:    sum = acc_q + prod_ext;
    endcase
  end

  // fit(): rescale the sum to sample width. The build option picks
  // saturation or wrap.
`ifdef IIR_INV_SAT_EN
  logic signed [AW-1:0] sum_sh;
  logic                 sum_ovf;
  assign sum_sh  = sum >>> frac_bits;
  // The value fits only if every bit above the sample's sign bit matches it.
  assign sum_ovf = (sum_sh[AW-1:bitwidth-1] != '0) && (sum_sh[AW-1:bitwidth-1] != '1);
  always_comb begin
    fit_val = sum_sh[bitwidth-1:0];
    if (sum_ovf) begin
      fit_val = sum_sh[AW-1] ? {1'b1, {(bitwidth-1){1'b0}}}
                             : {1'b0, {(bitwidth-1){1'b1}}};
    end
  end
`else
  assign fit_val = bitwidth'(sum >>> frac_bits);
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    z1_d        = z1_q;
    z2_d        = z2_q;
    w_d         = w_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = x_ext;
          k_d     = 3'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        k_d = k_q + 3'd1;
        case (k_q)
          3'd1: w_d = fit_val;
          3'd4: begin
            // The delay line shifts only here. It is held through OUT and IDLE.
            y_d         = fit_val;
            z2_d        = z1_q;
            z1_d        = w_q;
            out_valid_d = 1'b1;
            k_d         = 3'd0;
            state_d     = S_OUT;
          end
          default: acc_d = sum;
        endcase
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      w_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      w_q         <= w_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule
